// File: rtl/sr_cmd_pkg.sv
// Shared definitions for the SR latch command driver: sequencer states,
// latch command codes and a small helper that maps a request to its code.
package sr_cmd_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE    = 2'd0;
  localparam state_t SETUP   = 2'd1;
  localparam state_t ENABLE  = 2'd2;
  localparam state_t RELEASE = 2'd3;

  localparam logic [1:0] SR_HOLD    = 2'b00;
  localparam logic [1:0] SR_RESET   = 2'b01;
  localparam logic [1:0] SR_SET     = 2'b10;
  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  function automatic logic [1:0] pick_code(input logic want_set);
    return want_set ? SR_SET : SR_RESET;
  endfunction

endpackage

// File: rtl/sr_cmd_driver_sync_debounce.sv
// Two-flop synchroniser followed by a stability counter. The debounced level
// only follows the synchronised input after it has held its new value long
// enough; a registered one-cycle pulse marks each debounced 0->1 change.
module sync_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic deb_out,
  output logic rise_pulse
);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  // Bring the asynchronous button level into the clk domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  // Count stable disagreeing cycles; flip the debounced level once the count is full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 8'd0;
      deb_out    <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      rise_pulse <= 1'b0;
      if (sync2 != deb_out) begin
        if (cnt == 8'(DEB_CYCLES)) begin
          deb_out    <= sync2;
          cnt        <= 8'd0;
          rise_pulse <= sync2;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end else begin
        cnt <= 8'd0;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_driver.sv
// Front-end for the enabled SR latch: debounces the set/reset buttons, queues
// one request of each kind, arbitrates collisions and plays out a registered
// setup / enable / release write so sr never moves while e is high.
module sr_cmd_driver
  import sr_cmd_pkg::*;
#(
  parameter int DEB_CYCLES  = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_in,
  input  logic       rst_in,
  output logic [1:0] sr,
  output logic       e,
  output logic       busy,
  output logic       conflict,
  output logic       q_model
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

  logic       set_deb, set_rise;
  logic       rst_deb, rst_rise;
  logic       req_set, req_rst;
  logic       pend_set, pend_rst;
  logic       want_set, want_rst;
  state_t     state;
  logic [1:0] code;
  logic [7:0] hold_cnt;

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_set_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (set_in),
    .deb_out    (set_deb),
    .rise_pulse (set_rise)
  );

  sync_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rst_deb (
    .clk        (clk),
    .rst_n      (rst_n),
    .raw_in     (rst_in),
    .deb_out    (rst_deb),
    .rise_pulse (rst_rise)
  );

  // Qualify each rise with its level so a stale pulse can never launch a write
  always_comb begin
    req_set  = set_rise & set_deb;
    req_rst  = rst_rise & rst_deb;
    want_set = pend_set | req_set;
    want_rst = pend_rst | req_rst;
  end

  // Sequencer, pending flags and arbitration; every output is a flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      code     <= SR_HOLD;
      hold_cnt <= 8'd0;
      sr       <= SR_HOLD;
      e        <= 1'b0;
      busy     <= 1'b0;
      conflict <= 1'b0;
      q_model  <= 1'b0;
      pend_set <= 1'b0;
      pend_rst <= 1'b0;
    end else begin
      conflict <= 1'b0;
      if (state != IDLE) begin
        pend_set <= pend_set | req_set;
        pend_rst <= pend_rst | req_rst;
      end
      case (state)
        IDLE: begin
          if (want_set && want_rst) begin
            conflict <= 1'b1;
            pend_set <= 1'b0;
            pend_rst <= 1'b0;
          end else if (want_set || want_rst) begin
            state    <= SETUP;
            busy     <= 1'b1;
            code     <= pick_code(want_set);
            sr       <= pick_code(want_set);
            pend_set <= 1'b0;
            pend_rst <= 1'b0;
          end
        end
        SETUP: begin
          state    <= ENABLE;
          e        <= 1'b1;
          hold_cnt <= 8'd0;
        end
        ENABLE: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= RELEASE;
            e       <= 1'b0;
            q_model <= (code == SR_SET);
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          sr    <= SR_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_driver.sv
// Bench for sr_cmd_driver: directed scenarios plus random button activity,
// every cycle compared against a timeline model of the expected latch writes.
module tb_sr_cmd_driver;
  import sr_cmd_pkg::*;

  localparam int DEB  = 4;
  localparam int HOLD = 2;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       set_in = 1'b0;
  logic       rst_in = 1'b0;
  logic [1:0] sr;
  logic       e, busy, conflict, q_model;

  int checks = 0, failures = 0, cyc = 0;
  int e_seen = 0, conf_seen = 0, first_sr = -1;
  int base, base_e, base_c;

  // Reference model: raw sample history, run lengths, pending flags and
  // the offset of the current write within its setup/enable/release timeline
  bit         hs[2], hr[2];
  int         run_s, run_r;
  bit         deb_s, deb_r, rise_s, rise_r;
  bit         pend_s, pend_r, m_q, m_conf;
  int         phase;
  logic [1:0] m_code;

  always #5 clk = ~clk;

  sr_cmd_driver #(.DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_in   (set_in),
    .rst_in   (rst_in),
    .sr       (sr),
    .e        (e),
    .busy     (busy),
    .conflict (conflict),
    .q_model  (q_model)
  );

  task automatic model_reset();
    hs[0] = 0; hs[1] = 0; hr[0] = 0; hr[1] = 0;
    run_s = 0; run_r = 0; deb_s = 0; deb_r = 0; rise_s = 0; rise_r = 0;
    pend_s = 0; pend_r = 0; m_q = 0; m_conf = 0; phase = -1; m_code = SR_HOLD;
  endtask

  // A level is accepted on its (DEB+1)-th consecutive differing sample
  task automatic deb_step(input bit s, inout int run, inout bit deb, output bit rise);
    rise = 0;
    if (s != deb) begin
      run++;
      if (run > DEB) begin
        deb  = s;
        run  = 0;
        rise = s;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic model_edge(input bit raw_s, input bit raw_r);
    bit idle_before, want_s, want_r, s_now, r_now;
    idle_before = (phase < 0);
    m_conf = 0;
    if (phase >= 0) phase++;
    if (phase == HOLD + 2) phase = -1;
    if (phase == HOLD + 1) m_q = (m_code == SR_SET);
    if (idle_before) begin
      want_s = pend_s | rise_s;
      want_r = pend_r | rise_r;
      pend_s = 0;
      pend_r = 0;
      if (want_s && want_r) m_conf = 1;
      else if (want_s) begin phase = 0; m_code = SR_SET; end
      else if (want_r) begin phase = 0; m_code = SR_RESET; end
    end else begin
      pend_s = pend_s | rise_s;
      pend_r = pend_r | rise_r;
    end
    s_now = hs[1]; hs[1] = hs[0]; hs[0] = raw_s;
    r_now = hr[1]; hr[1] = hr[0]; hr[0] = raw_r;
    deb_step(s_now, run_s, deb_s, rise_s);
    deb_step(r_now, run_r, deb_r, rise_r);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [1:0] xsr;
    xsr = (phase >= 0) ? m_code : SR_HOLD;
    chk("sr", 8'(sr), 8'(xsr));
    chk("e", 8'(e), 8'(phase >= 1 && phase <= HOLD));
    chk("busy", 8'(busy), 8'(phase >= 0));
    chk("conflict", 8'(conflict), 8'(m_conf));
    chk("q_model", 8'(q_model), 8'(m_q));
    chk("sr_legal", 8'(sr === SR_ILLEGAL), 8'd0);
    if (e === 1'b1) e_seen++;
    if (conflict === 1'b1) conf_seen++;
    if (sr !== SR_HOLD && first_sr < 0) first_sr = cyc;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(set_in, rst_in);
    else model_reset();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input bit s, input bit r, input int n);
    set_in = s;
    rst_in = r;
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();

    $display("[TB] reset then idle");
    applyStimulus(0, 0, 3);
    rst_n = 1'b1;
    applyStimulus(0, 0, 5);

    $display("[TB] clean set");
    base_e = e_seen; first_sr = -1; base = cyc;
    applyStimulus(1, 0, 10);
    applyStimulus(0, 0, 12);
    chk("set_latency", 8'(first_sr - (base + 1)), 8'(DEB + 3));
    chk("set_e_width", 8'(e_seen - base_e), 8'(HOLD));
    chk("set_q", 8'(q_model), 8'd1);

    $display("[TB] bounce rejection");
    base_e = e_seen;
    for (int i = 0; i < 12; i++) applyStimulus(bit'(i % 2 == 0), 0, 1);
    applyStimulus(0, 0, 12);
    chk("bounce_e", 8'(e_seen - base_e), 8'd0);
    chk("bounce_q", 8'(q_model), 8'd1);

    $display("[TB] simultaneous requests");
    base_e = e_seen; base_c = conf_seen;
    applyStimulus(1, 1, 10);
    applyStimulus(0, 0, 12);
    chk("collide_conflicts", 8'(conf_seen - base_c), 8'd1);
    chk("collide_e", 8'(e_seen - base_e), 8'd0);
    chk("collide_q", 8'(q_model), 8'd1);

    $display("[TB] queued reset behind set");
    base_e = e_seen;
    applyStimulus(1, 0, 2);
    applyStimulus(1, 1, 10);
    applyStimulus(0, 0, 20);
    chk("queued_e", 8'(e_seen - base_e), 8'(2 * HOLD));
    chk("queued_q", 8'(q_model), 8'd0);

    $display("[TB] reset mid-sequence");
    applyStimulus(1, 0, DEB + 5);
    chk("mid_e_high", 8'(e), 8'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_sr", 8'(sr), 8'd0);
    chk("abort_e", 8'(e), 8'd0);
    chk("abort_busy", 8'(busy), 8'd0);
    model_reset();
    applyStimulus(0, 0, 3);
    rst_n = 1'b1;
    base_e = e_seen;
    applyStimulus(0, 0, 15);
    chk("abort_no_residual", 8'(e_seen - base_e), 8'd0);
    chk("abort_q", 8'(q_model), 8'd0);

    $display("[TB] random button activity");
    repeat (40) applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              int'($urandom_range(1, 12)));
    applyStimulus(0, 0, 25);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_cmd_driver.md
Name: sr_cmd_driver

Overview:
- Clocked front-end that drives the sr[1:0]/e inputs of the team's enabled SR latch.
- Takes two raw push-button style requests (set, reset) and synchronises and debounces each one.
- Turns each debounced rising edge into a timed latch write: sr set up first, then an e pulse, then release.
- Never presents sr=11 to the latch, and exports a shadow copy of the latch state for checking.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronised cycles needed before a debounced input changes. Range 1..255.
- HOLD_CYCLES, 2: width of the e pulse in clk cycles. Range 1..255.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- set_in  in  1  raw set request, asynchronous to clk, may bounce.
- rst_in  in  1  raw reset request, asynchronous to clk, may bounce.
- sr  out  2  latch command: 00 hold, 01 reset (q=0), 10 set (q=1); 11 never driven.
- e  out  1  latch enable pulse.
- busy  out  1  high while a write sequence is in progress (state != IDLE).
- conflict  out  1  one-cycle pulse when a set and a reset request collide and both are dropped.
- q_model  out  1  expected latch q after the last completed write.

Behaviour:
- Reset: rst_n low asynchronously clears everything:
  - sr=00, e=0, busy=0, conflict=0, q_model=0, state=IDLE.
  - Synchroniser flops, debounced values and counters = 0; pending flags cleared.
  - Asserting rst_n mid-sequence aborts it immediately, with no further e pulse.
- Synchroniser: two flops per input, so 2 cycles of latency.
- Debounce, per input:
  - A counter increments while the synchronised value differs from the debounced value.
  - The counter clears when the two are equal.
  - When the count reaches DEB_CYCLES, the debounced value flips and the counter clears.
- Request generation: a debounced 0->1 transition raises a one-cycle request (req_set / req_rst). Falling edges are ignored.
- Pending: each request type sets a one-deep pending flag. A repeat request of the same type while already pending is absorbed.
- Arbitration, evaluated in IDLE and also on the cycle a new request arrives:
  - Both pending (or both requests in the same cycle): pulse conflict for 1 cycle, clear both flags, stay IDLE.
  - Only set pending: go to SETUP with code 10. Only reset pending: code 01. The flag clears on entry to SETUP.
- State machine:
  - IDLE: sr=00, e=0.
  - SETUP: sr=code, e=0, 1 cycle.
  - ENABLE: sr=code, e=1 for HOLD_CYCLES cycles (counter).
  - RELEASE: sr=code, e=0, 1 cycle; q_model updates to 1 for set, 0 for reset.
  - Then back to IDLE, where sr returns to 00.
- Latency: a request seen in cycle t gives SETUP in t+1, e high in t+2..t+1+HOLD_CYCLES, RELEASE in t+2+HOLD_CYCLES, IDLE in t+3+HOLD_CYCLES.
- Requests during busy: held pending and serviced on return to IDLE. If the opposite type is also pending by then, a conflict is raised as above.
- Outputs are registered; sr and e are glitch-free.
- sr only changes while e=0: setup and hold of one cycle each around the e pulse.
- q_model matches the latch output once the sequence completes. Re-setting when q_model is already 1 still performs a full sequence.

Decomposition:
- Package sr_cmd_pkg:
  - state enum {IDLE, SETUP, ENABLE, RELEASE}.
  - Constants SR_HOLD=2'b00, SR_RESET=2'b01, SR_SET=2'b10, SR_ILLEGAL=2'b11. SR_ILLEGAL is used only by the checker.
- Sub-module sync_debounce:
  - Parameter DEB_CYCLES; ports clk, rst_n, raw_in, deb_out, rise_pulse.
  - Instantiated twice, once per input.
- FSM, pending flags and arbitration stay in the top level.

Test Plan:
- Reset then idle: rst_n=0 for 3 cycles, then 1 with inputs low -> sr=00, e=0, busy=0, conflict=0, q_model=0 throughout.
- Clean set, defaults: set_in held high 10 cycles -> SETUP 7 cycles after the first sampled rising edge (2 sync + 4 debounce + 1); sr=10 for 4 cycles; e=1 for exactly 2 of them (the middle two); q_model=1; sr back to 00.
- Bounce rejection: set_in toggled every cycle for 12 cycles, then low -> no request, e never 1, q_model unchanged.
- Simultaneous requests: set_in and rst_in rise on the same clk edge and stay high -> conflict=1 for one cycle, no e pulse, q_model unchanged, sr never 11.
- Queued request: reset request while a set sequence is in ENABLE -> set completes (q_model=1), then a reset sequence starts the cycle after IDLE is re-entered with sr=01, ending with q_model=0.
- Reset mid-sequence: rst_n pulled low during ENABLE -> e and sr drop to 0 asynchronously; after release no residual sequence runs and q_model=0.
